// File: rtl/nop_phit_deserializer.sv
// Packs PHITS_PER_FLIT phits popped from a 1-cycle-latency FIFO read port into
// one flit and presents it on a valid/ready interface with full backpressure.
module nop_phit_deserializer #(
  parameter int PHIT_WIDTH     = 16,
  parameter int PHITS_PER_FLIT = 4
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [PHIT_WIDTH-1:0]                fifo_rd_data,
  input  logic                                 fifo_empty,
  output logic                                 fifo_rd_en,
  output logic [PHIT_WIDTH*PHITS_PER_FLIT-1:0] flit_data,
  output logic                                 flit_valid,
  input  logic                                 flit_ready
);

  // Handshake: a flit transfers on a clk edge where flit_valid and flit_ready
  // are both 1; flit_data is held stable while flit_valid=1 and flit_ready=0.

  localparam int P  = PHITS_PER_FLIT;
  localparam int CW = $clog2(P + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(P);
  localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
  localparam logic [CW:0]   P_WIDE   = (CW + 1)'(P);

  logic                           run;
  logic                           pend;
  logic [CW-1:0]                  cnt;
  logic [P-1:0][PHIT_WIDTH-1:0]   asm_buf;

  logic [CW-1:0]                  cnt_d;
  logic [P-1:0][PHIT_WIDTH-1:0]   asm_d;
  logic [PHIT_WIDTH*P-1:0]        data_d;
  logic                           valid_d;
  logic                           out_free;
  logic [CW:0]                    in_flight;

  // Phits already held plus the one still in flight bound further pops.
  assign in_flight  = {1'b0, cnt} + (CW + 1)'(pend);
  assign fifo_rd_en = run & ~fifo_empty & (in_flight < P_WIDE);
  assign out_free   = ~flit_valid | flit_ready;

  always_comb begin
    cnt_d   = cnt;
    asm_d   = asm_buf;
    data_d  = flit_data;
    valid_d = flit_valid;
    if (flit_valid && flit_ready) valid_d = 1'b0;
    if (pend) begin
      if (cnt == CNT_LAST && out_free) begin
        // Last phit goes straight to the output register, skipping asm_buf.
        data_d  = {fifo_rd_data, asm_buf[P-2:0]};
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        for (int i = 0; i < P; i++) begin
          if (cnt == CW'(i)) asm_d[i] = fifo_rd_data;
        end
        cnt_d = cnt + CW'(1);
      end
    end else if (cnt == CNT_FULL && out_free) begin
      data_d  = asm_buf;
      valid_d = 1'b1;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run        <= 1'b0;
      pend       <= 1'b0;
      cnt        <= '0;
      asm_buf    <= '0;
      flit_data  <= '0;
      flit_valid <= 1'b0;
    end else begin
      run        <= 1'b1;
      pend       <= fifo_rd_en;
      cnt        <= cnt_d;
      asm_buf    <= asm_d;
      flit_data  <= data_d;
      flit_valid <= valid_d;
    end
  end

endmodule

// File: doc/nop_phit_deserializer.md
# nop_phit_deserializer

Consumer stage on the read side of the NoP link asynchronous FIFO. It pops PHIT_WIDTH-bit phits from the FIFO's read port, which has 1-cycle registered read latency. It packs PHITS_PER_FLIT consecutive phits into one flit and presents each flit on a valid/ready interface to the router input port. It never over-reads, never drops or duplicates a phit, and fully absorbs router backpressure.

## Interface
Parameters:
- PHIT_WIDTH, 16, width of one FIFO word (matches FIFO DATA_WIDTH).
- PHITS_PER_FLIT, 4, phits per flit; legal range 2..16.

Ports:
- clk  in  1  single clock; the FIFO read clock.
- rstn  in  1  asynchronous active-low reset.
- fifo_rd_data  in  PHIT_WIDTH  FIFO read data; valid the cycle after a pop.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  pop request; a pop occurs on the clk edge when fifo_rd_en=1.
- flit_data  out  PHIT_WIDTH*PHITS_PER_FLIT  assembled flit; phit 0 is in the LSBs.
- flit_valid  out  1  flit_data holds a flit.
- flit_ready  in  1  router accepts the flit at a clk edge when valid and ready are both 1.

## Operation
- State registers:
  - run: reset 0; set on the first clk edge after rstn deasserts.
  - pend: 1 = a pop was issued last cycle and its data lands this cycle.
  - cnt: phits held in the assembly buffer, 0..PHITS_PER_FLIT, width $clog2(PHITS_PER_FLIT+1).
  - asm: assembly buffer of PHITS_PER_FLIT phit slots.
  - out register: flit_data and flit_valid.
- fifo_rd_en = run & ~fifo_empty & (cnt + pend < PHITS_PER_FLIT).
  - Combinational from registers and fifo_empty only; never depends on flit_ready.
  - Never 1 while fifo_empty=1.
- pend <= fifo_rd_en on every edge.
- Landing: when pend=1, fifo_rd_data is written into slot cnt of asm, then cnt increments.
- out_free = ~flit_valid | flit_ready.
- Flit completion:
  - Bypass: the landing phit makes cnt reach PHITS_PER_FLIT and out_free=1. Load flit_data with {fifo_rd_data, asm[P-2:0]}, set flit_valid, set cnt to 0. asm is not written.
  - Stall: the landing phit completes the flit and out_free=0. cnt becomes PHITS_PER_FLIT and the flit stays in asm.
  - Drain from stall: when cnt=PHITS_PER_FLIT and out_free=1, flit_data <= asm, flit_valid <= 1, cnt <= 0.
- Stall cannot coincide with a landing phit, because pend=0 whenever cnt=PHITS_PER_FLIT.
- Output register:
  - flit_valid is cleared on acceptance when no new flit is loaded in the same cycle.
  - Acceptance and a new load in the same cycle leave flit_valid at 1 with the new data.
  - flit_data is stable while flit_valid=1 and flit_ready=0.
- Reset, including mid-flit:
  - All registers clear immediately and any partial flit is discarded.
  - A phit popped in the cycle before reset is lost; the link-level reset of both FIFO sides handles recovery.
- Reset values: fifo_rd_en=0, flit_valid=0, flit_data=0, cnt=0, pend=0, run=0.

## Timing
- fifo_rd_en is 0 for the whole of reset and during the first cycle after release, because run=0.
- Pop-to-land latency: 1 cycle.
- Peak throughput: one flit per PHITS_PER_FLIT+1 cycles. Reads stop for one cycle while the last phit is in flight.
- First flit: flit_valid rises PHITS_PER_FLIT+1 cycles after the first fifo_rd_en=1, given a non-empty FIFO and flit_ready=1.
- flit_ready=0:
  - At most one flit sits in the out register and one complete flit sits in asm.
  - fifo_rd_en then stays 0 until the stalled flit drains.
- Stalled-flit recovery:
  - On the edge where the router accepts the out-register flit, the flit stalled in asm loads into the out register, so the next flit_valid=1 cycle follows with no gap.
  - fifo_rd_en resumes in the cycle after that edge.

## Test plan
- Reset:
  - Stimulus: hold rstn=0 with fifo_empty=0.
  - Response: fifo_rd_en=0 and flit_valid=0 throughout; release rstn; fifo_rd_en stays 0 for exactly one cycle, then rises.
- Streaming, PHITS_PER_FLIT=4:
  - Stimulus: FIFO preloaded with 0x0001..0x0008, flit_ready=1.
  - Response: flit 0x0004_0003_0002_0001 becomes valid 5 cycles after the first pop; flit 0x0008_0007_0006_0005 becomes valid 5 cycles later; exactly 8 pops in total.
- Backpressure:
  - Stimulus: flit_ready=0 while FIFO holds 12 phits.
  - Response: flit 1 held stable; 4 further pops complete flit 2 in asm; fifo_rd_en then stays 0. Raise flit_ready: flit 1 accepted, flit 2 valid on the next cycle, flit 3 follows; no loss or duplication.
- Empty bubbles:
  - Stimulus: fifo_empty toggled randomly mid-flit.
  - Response: fifo_rd_en is never 1 while fifo_empty=1; phits assemble in pop order.
- Reset mid-flit:
  - Stimulus: assert rstn=0 when cnt=2.
  - Response: flit_valid drops at once; after release, the next phit lands in the LSBs of a new flit.
- PHITS_PER_FLIT=2, PHIT_WIDTH=8:
  - Stimulus: FIFO preloaded with 0xA1, 0xB2.
  - Response: flit 0xB2A1 becomes valid 3 cycles after the first pop.
